// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default
// latencies and controller state encoding.
package mdu_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multiply/divide unit owning architectural HI/LO. Results are computed in
// the start cycle into shadow registers and committed after a modelled
// MULT/DIV latency; md_stall lets the hazard unit hold dependent instructions.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] shadow_hi_q, shadow_hi_d;
    logic [31:0] shadow_lo_q, shadow_lo_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;

    // Arithmetic on the E-stage operands. Signed divide works on magnitudes
    // so 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    always_comb begin
        prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        prod_u = {32'b0, rs} * {32'b0, rt};
        a_mag  = rs[31] ? (32'd0 - rs) : rs;
        b_mag  = rt[31] ? (32'd0 - rt) : rt;
        q_mag  = '0;
        r_mag  = '0;
        quot_u = '0;
        rem_u  = '0;
        if (rt != '0) begin
            q_mag  = a_mag / b_mag;
            r_mag  = a_mag % b_mag;
            quot_u = rs / rt;
            rem_u  = rs % rt;
        end
        quot_s = (rs[31] ^ rt[31]) ? (32'd0 - q_mag) : q_mag;
        rem_s  = rs[31] ? (32'd0 - r_mag) : r_mag;
    end

    // State, counter, HI/LO and shadow registers with async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            shadow_hi_q <= '0;
            shadow_lo_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            shadow_hi_q <= shadow_hi_d;
            shadow_lo_q <= shadow_lo_d;
        end
    end

    // Next-state: accept ops only in IDLE, count down in BUSY, commit at zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        shadow_hi_d = shadow_hi_q;
        shadow_lo_d = shadow_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT: begin
                            {shadow_hi_d, shadow_lo_d} = prod_s;
                            cnt_d   = MULT_LOAD;
                            state_d = ST_BUSY;
                        end
                        MD_MULTU: begin
                            {shadow_hi_d, shadow_lo_d} = prod_u;
                            cnt_d   = MULT_LOAD;
                            state_d = ST_BUSY;
                        end
                        MD_DIV, MD_DIVU: begin
                            // HI/LO cannot change while busy, so capturing them
                            // here makes a divide by zero commit the old values.
                            if (rt == '0) begin
                                shadow_hi_d = hi_q;
                                shadow_lo_d = lo_q;
                            end else if (md_op == MD_DIV) begin
                                shadow_hi_d = rem_s;
                                shadow_lo_d = quot_s;
                            end else begin
                                shadow_hi_d = rem_u;
                                shadow_lo_d = quot_u;
                            end
                            cnt_d   = DIV_LOAD;
                            state_d = ST_BUSY;
                        end
                        MD_MTHI: hi_d = rs;
                        MD_MTLO: lo_d = rs;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    hi_d    = shadow_hi_q;
                    lo_d    = shadow_lo_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: busy from state, stall raised combinationally in the start cycle.
    always_comb begin
        busy     = (state_q == ST_BUSY);
        md_stall = busy | (start & is_long_op(md_op));
        hi       = hi_q;
        lo       = lo_q;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: long-op latency and results, MTHI/MTLO,
// divide by zero, start-while-busy and asynchronous reset.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs       (rs),
        .rt       (rt),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an op for one cycle starting at the next falling edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        rs    = a;
        rt    = b;
        #1;
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        rs    = '0;
        rt    = '0;
        #1;
    endtask

    task automatic test_reset();
        n_tests++;
        if (busy !== 1'b0 || md_stall !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b stall=%b hi=%h lo=%h required 0 0 0 0",
                     busy, md_stall, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Table of long ops: check stall in T0, busy for N cycles, results at T0+N+1.
    task automatic test_long_ops();
        logic [2:0]  v_op [6];
        logic [31:0] v_a  [6];
        logic [31:0] v_b  [6];
        logic [31:0] v_hi [6];
        logic [31:0] v_lo [6];
        int          v_n  [6];
        v_op[0] = MD_MULT;  v_a[0] = 32'hFFFFFFFE; v_b[0] = 32'd3;        v_hi[0] = 32'hFFFFFFFF; v_lo[0] = 32'hFFFFFFFA; v_n[0] = 5;
        v_op[1] = MD_MULTU; v_a[1] = 32'hFFFFFFFF; v_b[1] = 32'hFFFFFFFF; v_hi[1] = 32'hFFFFFFFE; v_lo[1] = 32'h00000001; v_n[1] = 5;
        v_op[2] = MD_MULT;  v_a[2] = 32'h80000000; v_b[2] = 32'd2;        v_hi[2] = 32'hFFFFFFFF; v_lo[2] = 32'h00000000; v_n[2] = 5;
        v_op[3] = MD_DIV;   v_a[3] = 32'hFFFFFFF9; v_b[3] = 32'd2;        v_hi[3] = 32'hFFFFFFFF; v_lo[3] = 32'hFFFFFFFD; v_n[3] = 10;
        v_op[4] = MD_DIV;   v_a[4] = 32'h80000000; v_b[4] = 32'hFFFFFFFF; v_hi[4] = 32'h00000000; v_lo[4] = 32'h80000000; v_n[4] = 10;
        v_op[5] = MD_DIVU;  v_a[5] = 32'hFFFFFFF9; v_b[5] = 32'd2;        v_hi[5] = 32'h00000001; v_lo[5] = 32'h7FFFFFFC; v_n[5] = 10;
        for (int i = 0; i < 6; i++) begin
            issue(v_op[i], v_a[i], v_b[i]);
            n_tests++;
            if (md_stall !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL long_t0[%0d]: stall=%b busy=%b required stall=1 busy=0", i, md_stall, busy);
            end
            release_start();
            for (int k = 1; k <= v_n[i]; k++) begin
                n_tests++;
                if (busy !== 1'b1 || md_stall !== 1'b1) begin
                    n_fail++;
                    $display("FAIL long_busy[%0d] cycle T0+%0d: busy=%b stall=%b required 1 1",
                             i, k, busy, md_stall);
                end
                @(negedge clk);
                #1;
            end
            n_tests++;
            if (busy !== 1'b0 || md_stall !== 1'b0 || hi !== v_hi[i] || lo !== v_lo[i]) begin
                n_fail++;
                $display("FAIL long_result[%0d]: busy=%b stall=%b hi=%h lo=%h required 0 0 %h %h",
                         i, busy, md_stall, hi, lo, v_hi[i], v_lo[i]);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        issue(MD_MTHI, 32'hDEADBEEF, 32'h0);
        n_tests++;
        if (md_stall !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_t0: stall=%b busy=%b required 0 0", md_stall, busy);
        end
        issue(MD_MTLO, 32'h00001234, 32'h0);
        n_tests++;
        if (hi !== 32'hDEADBEEF || lo !== 32'h7FFFFFFC || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_t1: hi=%h lo=%h busy=%b required deadbeef 7ffffffc 0", hi, lo, busy);
        end
        release_start();
        n_tests++;
        if (hi !== 32'hDEADBEEF || lo !== 32'h00001234 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo_t2: hi=%h lo=%h busy=%b required deadbeef 00001234 0", hi, lo, busy);
        end
    endtask

    task automatic test_none();
        issue(MD_NONE, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n_tests++;
        if (md_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL none_stall: stall=%b required 0", md_stall);
        end
        release_start();
        n_tests++;
        if (hi !== 32'hDEADBEEF || lo !== 32'h00001234 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL none_effect: hi=%h lo=%h busy=%b required deadbeef 00001234 0", hi, lo, busy);
        end
    endtask

    task automatic test_div_by_zero();
        issue(MD_MTHI, 32'h11, 32'h0);
        issue(MD_MTLO, 32'h22, 32'h0);
        issue(MD_DIVU, 32'd7, 32'd0);
        release_start();
        for (int k = 1; k <= 10; k++) begin
            n_tests++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL divz_busy cycle T0+%0d: busy=%b required 1", k, busy);
            end
            @(negedge clk);
            #1;
        end
        n_tests++;
        if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
            n_fail++;
            $display("FAIL divz_result: busy=%b hi=%h lo=%h required 0 00000011 00000022", busy, hi, lo);
        end
    endtask

    // MULT 6*7, then a DIV start while busy that must not disturb anything.
    task automatic test_back_to_back();
        issue(MD_MULT, 32'd6, 32'd7);
        release_start();
        issue(MD_DIV, 32'd100, 32'd3);
        n_tests++;
        if (busy !== 1'b1 || md_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_t2: busy=%b stall=%b required 1 1", busy, md_stall);
        end
        release_start();
        for (int k = 3; k <= 5; k++) begin
            n_tests++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_busy cycle T0+%0d: busy=%b required 1", k, busy);
            end
            @(negedge clk);
            #1;
        end
        n_tests++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'd42) begin
            n_fail++;
            $display("FAIL b2b_result: busy=%b hi=%h lo=%h required 0 00000000 0000002a", busy, hi, lo);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'd42) begin
            n_fail++;
            $display("FAIL b2b_no_late_commit: busy=%b hi=%h lo=%h required 0 00000000 0000002a", busy, hi, lo);
        end
    endtask

    task automatic test_async_reset();
        issue(MD_MTHI, 32'h55, 32'h0);
        issue(MD_MTLO, 32'h66, 32'h0);
        issue(MD_MULT, 32'd3, 32'd4);
        release_start();
        issue(MD_DIV, 32'd9, 32'd2);
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || md_stall !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b stall=%b hi=%h lo=%h required 0 0 0 0",
                     busy, md_stall, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_no_commit: busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        md_op = MD_NONE;
        rs    = '0;
        rt    = '0;
        #2;
        test_reset();
        test_long_ops();
        test_mthi_mtlo();
        test_none();
        test_div_by_zero();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit fed by the E stage.
- Consumes the E-stage forwarded operands (rs/rt) plus a decoded MD opcode, and owns the architectural HI/LO registers.
- Models the multi-cycle latency of MULT/DIV so that MFHI/MFLO/MTHI/MTLO/MD instructions in D are stalled by the hazard unit until results commit.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle qualifier: E stage holds a valid MD instruction this cycle.
- md_op  input  3  operation code, encodings from shared package.
- rs  input  32  forwarded operand A (E-stage regRD1 after forwarding mux).
- rt  input  32  forwarded operand B (E-stage regRD2 after forwarding mux).
- busy  output  1  multi-cycle operation in flight.
- md_stall  output  1  busy | (start & md_op is MULT/MULTU/DIV/DIVU); consumed by hazard unit.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset (async, asserted any time): hi=0, lo=0, busy=0, counter=0, state=IDLE. Any in-flight operation is discarded; its shadow results never commit.
- md_op encodings:
  - NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - MFHI/MFLO are not ops: the E stage reads hi/lo combinationally.
- States:
  - IDLE: start with MULT/MULTU/DIV/DIVU at edge T0 → compute result from rs/rt into shadow_hi/shadow_lo. Load counter=N−1 (N = MULT_CYCLES or DIV_CYCLES). Go to BUSY.
  - BUSY: counter decrements each edge. At the edge where counter==0 → hi<=shadow_hi, lo<=shadow_lo, go to IDLE.
- Timing: busy is high for exactly N cycles, T0+1 .. T0+N. New hi/lo are visible in the first cycle with busy=0.
- MTHI/MTLO in IDLE with start: hi<=rs or lo<=rs at the next edge. Latency 1, no busy, the other register is untouched.
- start while busy: ignored entirely; no state, counter, or HI/LO change. The hazard unit guarantees this cannot occur.
- md_op=NONE with start: no effect.
- Arithmetic:
  - MULT: signed 32×32 → 64; hi=[63:32], lo=[31:0].
  - MULTU: same, unsigned.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned.
- Divide by zero: busy still runs DIV_CYCLES; hi/lo keep their prior values at commit.
- DIV of 0x80000000 by −1: lo=0x80000000, hi=0.
- md_stall is combinational: it is already high in cycle T0 so that a dependent instruction in D stalls immediately.
- flush has no effect on this block. Operations already started always complete.

Decomposition:
- Shared package (param.v): MD_NONE..MD_MTLO op codes, MULT_CYCLES/DIV_CYCLES defaults, IDLE/BUSY state constants.
- One natural sub-module: md_decode. It is combinational and maps instr_E opcode/funct to md_op and start, instantiated in the E-stage wrapper, not inside mdu_unit.
- The arithmetic stays inline.

Test Plan:
- MULT rs=0xFFFFFFFE(−2), rt=3, start at T0:
  - busy high for cycles T0+1..T0+5;
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA visible at T0+6;
  - md_stall high at T0..T0+5.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF:
  - after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=−7 (0xFFFFFFF9), rt=2:
  - 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=7, rt=0, with prior hi=0x11, lo=0x22:
  - busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
- MTHI rs=0xDEADBEEF at T0, then MTLO rs=0x1234 at T0+1:
  - hi=0xDEADBEEF from T0+1, lo=0x1234 from T0+2;
  - busy never asserts.
- MULT started, then a second start (DIV) at T0+2 while busy, then reset asserted asynchronously mid-cycle at T0+3:
  - second start is ignored;
  - on reset, busy, hi and lo go to 0 immediately (before the next clk edge);
  - no commit occurs afterwards.
